jk_input_conditioner: RTL and testbench
=======================================

JK_INPUT_CONDITIONER -- requirements
Module: jk_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a new input level (10 ms at 100 MHz).
REQ-002 Parameter TICK_DIV, default 100_000_000, clk cycles per auto-mode step (1 Hz at 100 MHz); legal range 2 and above.
REQ-003 clk  input  1  100 MHz board clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sw_j  input  1  raw asynchronous switch (SW0), J request.
REQ-006 sw_k  input  1  raw asynchronous switch (SW1), K request.
REQ-007 btn_step  input  1  raw asynchronous push-button, manual step request.
REQ-008 sw_mode  input  1  raw asynchronous switch; 0 = auto step, 1 = manual step.
REQ-009 J  output  1  debounced sw_j, registered, drives downstream JK flip-flop J.
REQ-010 K  output  1  debounced sw_k, registered, drives downstream JK flip-flop K.
REQ-011 step_en  output  1  single-cycle clock-enable pulse; downstream JK flip-flop evaluates J/K only in cycles where step_en=1.
REQ-012 step_cnt  output  8  count of step_en pulses issued, for LED display.

Function
REQ-013 Each raw input (sw_j, sw_k, btn_step, sw_mode) SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-014 Each synchronized input SHALL have an independent debouncer: debounced state plus counter; counter clears whenever the synchronized level equals the debounced state, otherwise increments.
REQ-015 Debounced state SHALL take the new level on the edge where the counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL clear on that same edge.
REQ-016 Any return to the old level before acceptance (bounce) SHALL clear the counter; no output change.
REQ-017 A raw level change held stable SHALL appear on J/K exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-018 Manual source: one-cycle pulse on the cycle after the debounced btn_step rises 0->1; holding the button SHALL NOT repeat; release SHALL produce no pulse.
REQ-019 Auto source: prescaler counts 0..TICK_DIV-1 and wraps; pulse in the cycle the prescaler equals TICK_DIV-1.
REQ-020 step_en SHALL equal the auto pulse when debounced mode=0, the manual pulse when debounced mode=1; the unselected source is ignored.
REQ-021 In manual mode the prescaler SHALL be held at 0.
REQ-022 On any debounced mode transition the prescaler SHALL clear to 0, step_en SHALL be 0 in that cycle, and a pending manual pulse SHALL be discarded.
REQ-023 step_en SHALL be registered, never combinational from inputs; at most one pulse per cycle, and never two in consecutive cycles.
REQ-024 step_cnt SHALL increment by 1 on the cycle after each step_en pulse and wrap 255->0.
REQ-025 J and K SHALL update independently of step_en; a J/K change coincident with step_en is presented to downstream with its new value in that cycle.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force J=0, K=0, step_en=0, step_cnt=0 and clear all synchronizers, debounced states, debounce counters, prescaler and edge-detect registers.
REQ-027 After rst deasserts, a switch already high SHALL be treated as a new change and appear after DEBOUNCE_CYCLES+2 edges; a button already held SHALL produce one manual pulse once accepted.
REQ-028 rst asserted mid-debounce or mid-prescale SHALL abandon that count; no step_en pulse is issued for it.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-029 sw_j 0->1 held -> J=1 exactly 6 edges later; K stays 0.
REQ-030 sw_k toggles 1,0,1 with 2-cycle spacing, then held 1 -> K stays 0 through the bounces, then rises 6 edges after the final stable 1.
REQ-031 sw_mode=0, free run of 32 cycles -> step_en pulses every 8 cycles, 4 pulses total, step_cnt=4.
REQ-032 sw_mode=1, btn_step held 20 cycles then released -> exactly one step_en pulse; step_cnt increments by 1.
REQ-033 256 auto steps from reset -> step_cnt wraps to 0.
REQ-034 rst pulsed asynchronously between clk edges with J=1 and step_cnt=5 -> J=0 and step_cnt=0 before the next edge; no step_en pulse until a full 8-cycle period after rst deasserts.

Source files
------------

// File: rtl/jk_input_conditioner.sv
// Input front end for a JK flip-flop demo board: synchronizes and debounces the
// J/K switches, mode switch and step button, and generates a step clock-enable.
module jk_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_j,
    input  logic       sw_k,
    input  logic       btn_step,
    input  logic       sw_mode,
    output logic       J,
    output logic       K,
    output logic       step_en,
    output logic [7:0] step_cnt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_PREV = PRE_W'(TICK_DIV - 2);

    // Bit map for all per-input vectors: 0 = J, 1 = K, 2 = step button, 3 = mode.
    logic [3:0]       raw;
    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       db;
    logic [CNT_W-1:0] db_cnt [4];

    logic             btn_prev;
    logic             mode_prev;
    logic [PRE_W-1:0] presc;
    logic             manual_rise;
    logic             mode_change;
    logic             auto_tick;

    assign raw = {sw_mode, btn_step, sw_k, sw_j};

    // Stage p0/p1: two-flop synchronizer per raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce stage: a level is accepted after DEBOUNCE_CYCLES consecutive disagreements
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db[i]     <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign J = db[0];
    assign K = db[1];

    assign manual_rise = db[2] & ~btn_prev;
    assign mode_change = db[3] ^ mode_prev;
    // Registered step_en is high while presc sits at TICK_DIV-1, so decide one count early.
    assign auto_tick   = (presc == PRE_PREV);

    // Step stage: source select, prescaler and pulse counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev  <= 1'b0;
            mode_prev <= 1'b0;
            presc     <= '0;
            step_en   <= 1'b0;
            step_cnt  <= '0;
        end else begin
            btn_prev  <= db[2];
            mode_prev <= db[3];
            if (mode_change) begin
                presc   <= '0;
                step_en <= 1'b0;
            end else if (db[3]) begin
                presc   <= '0;
                step_en <= manual_rise & ~step_en;
            end else begin
                presc   <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
                step_en <= auto_tick & ~step_en;
            end
            if (step_en) begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=8.
module tb_jk_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_j, sw_k, btn_step, sw_mode;
    logic       J, K, step_en;
    logic [7:0] step_cnt;

    int tests  = 0;
    int errors = 0;
    int pulses;
    int cnt0;

    jk_input_conditioner #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_j     (sw_j),
        .sw_k     (sw_k),
        .btn_step (btn_step),
        .sw_mode  (sw_mode),
        .J        (J),
        .K        (K),
        .step_en  (step_en),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_s();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw_j = 1'b0; sw_k = 1'b0; btn_step = 1'b0; sw_mode = 1'b0;
        #12;
        check("rst_J", J, 0);
        check("rst_K", K, 0);
        check("rst_step_en", step_en, 0);
        check("rst_step_cnt", step_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // J rise: visible exactly 6 edges after the first sampling edge
        @(negedge clk);
        sw_j = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            edge_s();
            check($sformatf("J_wait%0d", i), J, 0);
        end
        edge_s();
        check("J_rise", J, 1);
        check("K_quiet", K, 0);

        // K bounce 1,0 then stable 1
        @(negedge clk);
        sw_k = 1'b1;
        edge_s(); check("K_b1", K, 0);
        edge_s(); check("K_b2", K, 0);
        @(negedge clk);
        sw_k = 1'b0;
        edge_s(); check("K_b3", K, 0);
        edge_s(); check("K_b4", K, 0);
        @(negedge clk);
        sw_k = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            edge_s();
            check($sformatf("K_wait%0d", i), K, 0);
        end
        edge_s();
        check("K_rise", K, 1);

        // Auto mode free run: pulse after edges 7,15,23,31
        sw_j = 1'b0; sw_k = 1'b0;
        do_reset();
        pulses = 0;
        for (int i = 1; i <= 32; i++) begin
            edge_s();
            if (step_en) pulses++;
            if ((i % 8) == 7) check($sformatf("auto_pulse%0d", i), step_en, 1);
        end
        check("auto_pulses", pulses, 4);
        check("auto_cnt", step_cnt, 4);

        // Manual mode: one pulse per press regardless of hold time
        do_reset();
        @(negedge clk);
        sw_mode = 1'b1;
        for (int i = 0; i < 12; i++) edge_s();
        cnt0 = int'(step_cnt);
        check("mode_switch_no_pulse", step_en, 0);
        @(negedge clk);
        btn_step = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            edge_s();
            if (step_en) pulses++;
        end
        check("man_early", pulses, 0);
        edge_s();
        check("man_pulse", step_en, 1);
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            edge_s();
            if (step_en) pulses++;
        end
        @(negedge clk);
        btn_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            edge_s();
            if (step_en) pulses++;
        end
        check("man_no_repeat", pulses, 0);
        check("man_cnt", step_cnt, (cnt0 + 1) % 256);

        // 256 auto steps wrap step_cnt
        sw_mode = 1'b0;
        do_reset();
        pulses = 0;
        for (int i = 1; i <= 2047; i++) begin
            edge_s();
            if (step_en) pulses++;
        end
        check("wrap_255", step_cnt, 255);
        edge_s();
        check("wrap_0", step_cnt, 0);
        check("wrap_pulses", pulses, 256);

        // Switch already high at reset release, then async reset mid-count
        sw_j = 1'b1;
        do_reset();
        for (int i = 1; i <= 5; i++) edge_s();
        check("post_rst_J_wait", J, 0);
        edge_s();
        check("post_rst_J", J, 1);
        for (int i = 7; i <= 40; i++) edge_s();
        check("pre_async_J", J, 1);
        check("pre_async_cnt", step_cnt, 5);
        #1;
        rst = 1'b1;
        #1;
        check("async_J", J, 0);
        check("async_cnt", step_cnt, 0);
        check("async_step_en", step_en, 0);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            edge_s();
            if (step_en) pulses++;
        end
        check("async_no_early", pulses, 0);
        edge_s();
        check("async_first_pulse", step_en, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
